// File: rtl/flopary_pkg.sv
// Shared types, constants and width helpers for the flop-array read scheduler.
package flopary_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StSettle,
    StResp
  } sched_st_t;

  localparam int unsigned SETTLE_MIN = 1;

  // Width of a counter/index able to hold 0..n-1, never narrower than one bit.
  function automatic int unsigned bits_for(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  // Successor of idx in a ring of n slots.
  function automatic int unsigned ring_next(input int unsigned idx, input int unsigned n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin selector: first asserted request at or after ptr, wrapping.
module rr_pick #(
  parameter int unsigned NREQ   = 4,
  parameter int unsigned BITREQ = $clog2(NREQ)
) (
  input  logic [NREQ-1:0]   req,
  input  logic [BITREQ-1:0] ptr,
  output logic [NREQ-1:0]   gnt,
  output logic [BITREQ-1:0] idx,
  output logic              any
);

  always_comb begin : p_pick
    int unsigned k;
    logic [BITREQ-1:0] kk;
    gnt = '0;
    idx = '0;
    any = 1'b0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      k  = (32'(ptr) + i) % NREQ;
      kk = BITREQ'(k);
      if (!any && req[kk]) begin
        any     = 1'b1;
        gnt[kk] = 1'b1;
        idx     = kk;
      end
    end
  end

endmodule

// File: rtl/flopary_rd_sched.sv
// Round-robin read-port scheduler for the asynchronous flop array: registered mux select,
// programmable settle wait, then a registered response held under valid/ready backpressure.
module flopary_rd_sched
  import flopary_pkg::*;
#(
  parameter int unsigned NREQ   = 4,
  parameter int unsigned DEPTH  = 32,
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned SETTLE = 1,
  parameter int unsigned BITDEP = $clog2(DEPTH),
  parameter int unsigned BITREQ = $clog2(NREQ)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NREQ-1:0]        req_vld,
  input  logic [NREQ*BITDEP-1:0] req_adr,
  output logic [NREQ-1:0]        req_rdy,
  output logic [BITDEP-1:0]      mux_sel,
  input  logic [WIDTH-1:0]       mux_dout,
  output logic                   rsp_vld,
  input  logic                   rsp_rdy,
  output logic [BITREQ-1:0]      rsp_id,
  output logic                   rsp_err,
  output logic [WIDTH-1:0]       rsp_dat
);

  localparam int unsigned CNTW = bits_for(SETTLE);
  localparam logic [BITDEP:0] ADR_LIM = (BITDEP + 1)'(DEPTH);

  if (SETTLE < SETTLE_MIN) begin : g_bad_settle
    $error("SETTLE must be at least %0d", SETTLE_MIN);
  end
  if (NREQ < 2) begin : g_bad_nreq
    $error("NREQ must be at least 2");
  end

  sched_st_t         state_q, state_d;
  logic [BITREQ-1:0] ptr_q, ptr_d;
  logic [BITDEP-1:0] sel_q, sel_d;
  logic [BITREQ-1:0] id_q, id_d;
  logic              pend_err_q, pend_err_d;
  logic [CNTW-1:0]   cnt_q, cnt_d;
  logic              err_q, err_d;
  logic [WIDTH-1:0]  dat_q, dat_d;

  logic [NREQ-1:0]   pick_gnt;
  logic [BITREQ-1:0] pick_idx;
  logic              pick_any;
  logic              arb_en;
  logic              grant;
  logic [BITDEP-1:0] gnt_adr;
  logic              gnt_err;

  rr_pick #(
    .NREQ  (NREQ),
    .BITREQ(BITREQ)
  ) u_pick (
    .req(req_vld),
    .ptr(ptr_q),
    .gnt(pick_gnt),
    .idx(pick_idx),
    .any(pick_any)
  );

  // Arbitration is open in IDLE and in the RESP handshake cycle (back-to-back grant).
  always_comb begin
    arb_en  = (state_q == StIdle) || ((state_q == StResp) && rsp_rdy);
    grant   = arb_en && pick_any;
    req_rdy = arb_en ? pick_gnt : '0;
    gnt_adr = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (pick_gnt[i]) gnt_adr |= req_adr[i*BITDEP +: BITDEP];
    end
    gnt_err = ({1'b0, gnt_adr} >= ADR_LIM);
  end

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    sel_d      = sel_q;
    id_d       = id_q;
    pend_err_d = pend_err_q;
    cnt_d      = cnt_q;
    err_d      = err_q;
    dat_d      = dat_q;

    unique case (state_q)
      StIdle: ;
      StSettle: begin
        if (cnt_q == '0) begin
          dat_d   = pend_err_q ? '0 : mux_dout;
          err_d   = pend_err_q;
          state_d = StResp;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StResp: begin
        if (rsp_rdy) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    if (grant) begin
      state_d    = StSettle;
      // Out-of-range reads leave the mux tree untouched so it does not glitch for nothing.
      if (!gnt_err) sel_d = gnt_adr;
      id_d       = pick_idx;
      pend_err_d = gnt_err;
      cnt_d      = CNTW'(SETTLE - 1);
      ptr_d      = BITREQ'(ring_next(32'(pick_idx), NREQ));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      ptr_q      <= '0;
      sel_q      <= '0;
      id_q       <= '0;
      pend_err_q <= 1'b0;
      cnt_q      <= '0;
      err_q      <= 1'b0;
      dat_q      <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      sel_q      <= sel_d;
      id_q       <= id_d;
      pend_err_q <= pend_err_d;
      cnt_q      <= cnt_d;
      err_q      <= err_d;
      dat_q      <= dat_d;
    end
  end

  assign rsp_vld = (state_q == StResp);
  assign rsp_id  = id_q;
  assign rsp_err = err_q;
  assign rsp_dat = dat_q;
  assign mux_sel = sel_q;

endmodule
